// File: rtl/leaf_status_pkg.sv
// Shared defaults and entry layout for the leaf status aggregation node.
// No logic, so there is no latency.
// No flow control lives here.
package leaf_status_pkg;

    localparam int N_CHILD_DEF = 5;
    localparam int DATA_W_DEF  = 16;
    localparam int DEPTH_DEF   = 2;
    localparam int SEQ_W_DEF   = 8;
    localparam int SRC_W_DEF   = $clog2(N_CHILD_DEF);

    // Layout of one buffered word for the default configuration.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [SRC_W_DEF-1:0]  src;
        logic [SEQ_W_DEF-1:0]  seq;
    } status_entry_t;

endpackage

// File: rtl/leaf_status_arbiter_if.sv
// Child-side and parent-side valid/ready bundle of the aggregation node.
// Wires only, so there is no latency.
// The slave modport is the arbiter: it drives in_ready and out_*; the master drives valid/data/out_ready.
interface leaf_status_arbiter_if
    import leaf_status_pkg::*;
#(
    parameter int N_CHILD = N_CHILD_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEQ_W   = SEQ_W_DEF
);
    localparam int SRC_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

    logic [N_CHILD-1:0]        in_valid;
    logic [N_CHILD*DATA_W-1:0] in_data;
    logic [N_CHILD-1:0]        in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic [SEQ_W-1:0]          out_seq;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, out_seq
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, out_seq
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted req searching from ptr upwards, modulo N.
// Purely combinational, zero latency.
// No flow control of its own; the caller decides whether to act on the grant.
module rr_arbiter #(
    parameter int N = 5,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // Walk the N positions starting at ptr and keep the first requester found.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/leaf_status_arbiter.sv
// Round-robin merge of N_CHILD status channels into one tagged {data, src, seq} stream via a DEPTH FIFO.
// One cycle from handshake to out_valid when the FIFO is empty; later words queue in order.
// in_ready uses the count registered at cycle start, so a full FIFO refuses input even while popping.
module leaf_status_arbiter
    import leaf_status_pkg::*;
#(
    parameter int N_CHILD = N_CHILD_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int SEQ_W   = SEQ_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    leaf_status_arbiter_if.slave bus,
    output logic [15:0]          overflow_cnt
);

    localparam int SRC_W = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    // Same shape as status_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             last_q;
    entry_t             head;
    entry_t             push_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SEQ_W-1:0]   seq;
    logic [N_CHILD-1:0] gnt;
    logic               any_req;
    logic               full;
    logic               push;
    logic               pop;

    rr_arbiter #(.N(N_CHILD)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    assign full = (count == (PTR_W + 1)'(DEPTH));

    // The grant only lands on a valid child, so any grant offered is an accept.
    assign bus.in_ready = (full || rst) ? '0 : gnt;
    assign push         = any_req && !full && !rst;
    assign pop          = bus.out_valid && bus.out_ready;

    assign push_entry = '{data: bus.in_data[int'(gnt_idx) * DATA_W +: DATA_W],
                          src:  gnt_idx,
                          seq:  seq};

    // When empty the head slot is stale, so show the last word popped instead.
    assign head          = mem[rd_ptr];
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? head.data : last_q.data;
    assign bus.out_src   = bus.out_valid ? head.src  : last_q.src;
    assign bus.out_seq   = bus.out_valid ? head.seq  : last_q.seq;

    // Storage array; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy, arbitration pointer, sequence tag and hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
            seq    <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 1'b1;
                rr_ptr <= (int'(gnt_idx) == N_CHILD - 1) ? '0 : gnt_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= head;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of cycles where a child was blocked by a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_cnt <= '0;
        end else if (full && (|bus.in_valid) && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

endmodule

// File: doc/leaf_status_arbiter.md
Name: leaf_status_arbiter

Overview:
- Downstream aggregation stage for a five-child hierarchy node.
- Collects status words from N_CHILD leaf instances over independent valid/ready channels.
- Arbitrates between them round-robin, tags each word with its source index and a global sequence number, and buffers it in a small FIFO.
- Presents one serialized valid/ready output stream to the next level up.

Parameters:
- N_CHILD, 5, number of child input channels (2..8).
- DATA_W, 16, status word width.
- DEPTH, 2, output FIFO depth (power of two, >=2).
- SEQ_W, 8, sequence counter width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N_CHILD  per-child word valid.
- in_data  input  N_CHILD*DATA_W  per-child word; child i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N_CHILD  per-child accept; one-hot or zero.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  head word.
- out_src  output  $clog2(N_CHILD)  child index of head word.
- out_seq  output  SEQ_W  sequence number of head word.
- overflow_cnt  output  16  count of cycles where any in_valid was high while the FIFO was full; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release): FIFO count=0, wr/rd pointers=0, rr_ptr=0, seq=0, overflow_cnt=0.
- Output reset values: out_valid=0, out_data=0, out_src=0, out_seq=0, in_ready=0.
- Reset asserted mid-transfer discards all buffered words; no word is emitted after release until a new accept.
- Arbitration (combinational):
  - Active only when FIFO count < DEPTH, using count registered at the start of the cycle.
  - Grant goes to the first child with in_valid=1, searching indices rr_ptr, rr_ptr+1, … mod N_CHILD.
  - in_ready = one-hot of the grant; all zero when the FIFO is full or no child is valid.
  - in_ready may depend on in_valid. in_valid must not depend on in_ready (children's obligation).
- Accept (in_valid[g] & in_ready[g] at edge):
  - Push {in_data[g], g, seq} into the FIFO.
  - seq <= seq+1, wrapping 2^SEQ_W-1 -> 0.
  - rr_ptr <= (g+1) mod N_CHILD.
  - rr_ptr is unchanged on cycles with no accept.
- Latency: a word accepted at edge T is visible on out_* from after edge T if the FIFO was empty (one cycle from handshake). Otherwise it appears behind earlier words in order.
- Output:
  - out_valid = (count != 0).
  - out_data/out_src/out_seq driven from the FIFO head register.
  - Head pops when out_valid & out_ready.
  - out_* hold stable while out_valid=1 & out_ready=0.
  - out_data/src/seq keep their last value when empty (no X).
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full: no push in that cycle even if out_ready=1 (ready is based on the registered count; no pass-through). A pop frees a slot for the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- overflow_cnt increments by 1 on each cycle with count==DEPTH & |in_valid; saturates at 0xFFFF, never wraps.
- Starvation bound: a continuously valid child is granted within N_CHILD accepts.

Decomposition:
- Shared package leaf_status_pkg: DATA_W/SEQ_W defaults, N_CHILD default, and the typedef status_entry_t {data, src, seq}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, ptr.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Purely combinational; reused for other fan-in nodes.
- FIFO storage stays inline (small DEPTH).

Test Plan:
- Reset then idle, all in_valid=0 for 10 cycles -> out_valid=0, in_ready=0, overflow_cnt=0, out_data=0.
- Single child: in_valid[2]=1, in_data[2]=0x1234 for one cycle, out_ready=1 -> in_ready=5'b00100. Next cycle out_valid=1, out_data=0x1234, out_src=2, out_seq=0. rr_ptr becomes 3.
- All five valid continuously, out_ready=1 -> grant order 0,1,2,3,4,0,…; out_seq increments 0,1,2…; after 256 accepts out_seq wraps to 0.
- out_ready=0, children 0 and 1 valid -> two words accepted, then in_ready=0 and overflow_cnt increments each cycle. Raise out_ready -> words drain in order with seq 0 then 1, and no word is lost.
- Hold full with child 3 valid for 70000 cycles -> overflow_cnt saturates at 0xFFFF.
- Assert rst while the FIFO holds 2 words -> out_valid=0 immediately (async), count=0, seq=0 after release. The first new accept carries out_seq=0.
